operand_aligner: RTL and testbench

OPERAND_ALIGNER -- requirements
Module: operand_aligner

---
 rtl/fpu_pkg.sv | 39 +++
 rtl/align_shifter.sv | 75 +++++++
 rtl/operand_aligner.sv | 120 ++++++++++++
 tb/tb_operand_aligner.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  fpu_pkg : shared FPU constants, state encodings, operand fields, helpers
//  Revision: 1.0
// ============================================================================
package fpu_pkg;

    localparam int FP_WIDTH = 32;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int GRS_W    = 3;
    localparam int MANT_W   = 1 + FRAC_W + GRS_W;
    localparam int EXP_BIAS = 127;
    localparam int SHAMT_W  = 5;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPARE = 2'd1;
    localparam logic [1:0] ST_SHIFT   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef logic [1:0] state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  expn;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // {hidden, frac, G, R, S} with GRS cleared; denormals get hidden = 0
    function automatic logic [MANT_W-1:0] fp_mant(input fp32_t x);
        return {(x.expn != '0), x.frac, {GRS_W{1'b0}}};
    endfunction

    function automatic logic [EXP_W-1:0] fp_eff_exp(input fp32_t x);
        return (x.expn == '0) ? 8'd1 : x.expn;
    endfunction

endpackage
`default_nettype wire

// File: rtl/align_shifter.sv
`default_nettype none
// ============================================================================
//  align_shifter : right shifter with sticky for the smaller mantissa.
//  ALIGN_FAST_SHIFT_EN selects a one-cycle barrel shift, else 1 bit/cycle.
//  Revision: 1.0
// ============================================================================
module align_shifter
    import fpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [MANT_W-1:0]  mant_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic [MANT_W-1:0]  mant_o,
    output logic               last_o
);

    logic [MANT_W-1:0]  mant_q, mant_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;

`ifdef ALIGN_FAST_SHIFT_EN
    logic [MANT_W:0]   w_low_mask;
    logic [MANT_W-1:0] w_shifted;
    logic              w_sticky;

    // Bits [cnt:0] all collapse into the sticky position
    assign w_low_mask = ({{MANT_W{1'b0}}, 1'b1} << (cnt_q + 5'd1)) - {{MANT_W{1'b0}}, 1'b1};
    assign w_shifted  = mant_q >> cnt_q;
    assign w_sticky   = |({1'b0, mant_q} & w_low_mask);
    assign last_o     = 1'b1;

    always_comb begin
        mant_d = mant_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            mant_d = mant_i;
            cnt_d  = shamt_i;
        end else if (step_i) begin
            mant_d = (w_shifted & ~{{(MANT_W-1){1'b0}}, 1'b1})
                   | {{(MANT_W-1){1'b0}}, w_sticky};
            cnt_d  = '0;
        end
    end
`else
    assign last_o = (cnt_q == 5'd1);

    always_comb begin
        mant_d = mant_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            mant_d = mant_i;
            cnt_d  = shamt_i;
        end else if (step_i && (cnt_q != '0)) begin
            mant_d = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
            cnt_d  = cnt_q - 5'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant_q <= '0;
            cnt_q  <= '0;
        end else begin
            mant_q <= mant_d;
            cnt_q  <= cnt_d;
        end
    end

    assign mant_o = mant_q;

endmodule
`default_nettype wire

// File: rtl/operand_aligner.sv
`default_nettype none
// ============================================================================
//  operand_aligner : orders two IEEE-754 singles by magnitude and aligns the
//  smaller mantissa to the larger exponent. Option: ALIGN_FAST_SHIFT_EN.
//  Revision: 1.0
// ============================================================================
module operand_aligner
    import fpu_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    input  logic              op_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [MANT_W-1:0] ma_mant_o,
    output logic [MANT_W-1:0] mb_mant_o,
    output logic [EXP_W-1:0]  exp_big_o,
    output logic              ma_sign_o,
    output logic              mb_sign_o,
    output logic              op_out_o,
    output logic              swapped_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    state_t            state_q, state_d;
    fp32_t             a_q, b_q;
    logic              opin_q;
    logic [MANT_W-1:0] ma_mant_q;
    logic [EXP_W-1:0]  exp_big_q;
    logic              ma_sign_q, mb_sign_q, op_out_q, swapped_q;

    logic               w_swap, w_far, w_last;
    fp32_t              w_big, w_small;
    logic [EXP_W-1:0]   w_exp_big, w_diff;
    logic [MANT_W-1:0]  w_small_mant, w_load_mant;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_b_sign_eff;

    // Raw exponent/fraction ordering is the true magnitude order, denormals included
    assign w_swap       = (b_q.expn > a_q.expn) ||
                          ((b_q.expn == a_q.expn) && (b_q.frac > a_q.frac));
    assign w_big        = w_swap ? b_q : a_q;
    assign w_small      = w_swap ? a_q : b_q;
    assign w_b_sign_eff = b_q.sign ^ opin_q;
    assign w_exp_big    = fp_eff_exp(w_big);
    assign w_diff       = w_exp_big - fp_eff_exp(w_small);
    assign w_small_mant = fp_mant(w_small);
    assign w_far        = (w_diff >= 8'(MANT_W));
    assign w_load_mant  = w_far ? {{(MANT_W-1){1'b0}}, |w_small_mant} : w_small_mant;
    assign w_shamt      = w_far ? '0 : w_diff[SHAMT_W-1:0];

    align_shifter u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (state_q == ST_COMPARE),
        .step_i  (state_q == ST_SHIFT),
        .mant_i  (w_load_mant),
        .shamt_i (w_shamt),
        .mant_o  (mb_mant_o),
        .last_o  (w_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (in_valid_i) state_d = ST_COMPARE;
            ST_COMPARE: state_d = ((w_diff == '0) || w_far) ? ST_DONE : ST_SHIFT;
            ST_SHIFT:   if (w_last) state_d = ST_DONE;
            ST_DONE:    if (out_ready_i) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            opin_q    <= 1'b0;
            ma_mant_q <= '0;
            exp_big_q <= '0;
            ma_sign_q <= 1'b0;
            mb_sign_q <= 1'b0;
            op_out_q  <= 1'b0;
            swapped_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && in_valid_i) begin
                a_q    <= a_i;
                b_q    <= b_i;
                opin_q <= op_i;
            end
            if (state_q == ST_COMPARE) begin
                ma_mant_q <= fp_mant(w_big);
                exp_big_q <= w_exp_big;
                ma_sign_q <= w_swap ? w_b_sign_eff : a_q.sign;
                mb_sign_q <= w_swap ? a_q.sign : w_b_sign_eff;
                op_out_q  <= opin_q;
                swapped_q <= w_swap;
            end
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);
    assign ma_mant_o   = ma_mant_q;
    assign exp_big_o   = exp_big_q;
    assign ma_sign_o   = ma_sign_q;
    assign mb_sign_o   = mb_sign_q;
    assign op_out_o    = op_out_q;
    assign swapped_o   = swapped_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_aligner.sv
`default_nettype none
// ============================================================================
//  tb_operand_aligner : directed table-driven bench for operand_aligner
//  Revision: 1.0
// ============================================================================
module tb_operand_aligner;

    logic        clk;
    logic        rst_n;
    logic [31:0] a, b;
    logic        op, in_valid, in_ready, out_ready, out_valid;
    logic [26:0] ma_mant, mb_mant;
    logic [7:0]  exp_big;
    logic        ma_sign, mb_sign, op_out, swapped;

    int n_pass  = 0;
    int n_total = 0;

    operand_aligner #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_i         (a),
        .b_i         (b),
        .op_i        (op),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .ma_mant_o   (ma_mant),
        .mb_mant_o   (mb_mant),
        .exp_big_o   (exp_big),
        .ma_sign_o   (ma_sign),
        .mb_sign_o   (mb_sign),
        .op_out_o    (op_out),
        .swapped_o   (swapped),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        int          diff;
        logic [26:0] ma;
        logic [26:0] mb;
        logic [7:0]  expn;
        logic [3:0]  flags;   // {ma_sign, mb_sign, op_out, swapped}
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    // Rising edges counted from (and including) the accepting edge
    function automatic int exp_latency(input int diff);
        if (diff == 0 || diff >= 27) return 2;
`ifdef ALIGN_FAST_SHIFT_EN
        return 3;
`else
        return 2 + diff;
`endif
    endfunction

    task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vop);
        @(negedge clk);
        a = va; b = vb; op = vop; in_valid = 1'b1;
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_outputs(input vec_t v, input string tag);
        check({tag, "_ma"},    {5'd0, ma_mant}, {5'd0, v.ma});
        check({tag, "_mb"},    {5'd0, mb_mant}, {5'd0, v.mb});
        check({tag, "_exp"},   {24'd0, exp_big}, {24'd0, v.expn});
        check({tag, "_flags"}, {28'd0, ma_sign, mb_sign, op_out, swapped}, {28'd0, v.flags});
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_ready", {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 0,   27'h4000000, 27'h4000000, 8'h7F, 4'b0000};
        vecs[1]  = '{32'h3F000000, 32'h40000000, 1'b0, 2,   27'h4000000, 27'h1000000, 8'h80, 4'b0001};
        vecs[2]  = '{32'h4B000000, 32'h3F800000, 1'b0, 23,  27'h4000000, 27'h0000008, 8'h96, 4'b0000};
        vecs[3]  = '{32'h4E800000, 32'h3F800000, 1'b0, 30,  27'h4000000, 27'h0000001, 8'h9D, 4'b0000};
        vecs[4]  = '{32'hC0400000, 32'h3F800000, 1'b1, 1,   27'h6000000, 27'h2000000, 8'h80, 4'b1110};
        vecs[5]  = '{32'h3F800000, 32'h3FC00000, 1'b0, 0,   27'h6000000, 27'h4000000, 8'h7F, 4'b0001};
        vecs[6]  = '{32'h41800000, 32'h3F800001, 1'b0, 4,   27'h4000000, 27'h0400001, 8'h83, 4'b0000};
        vecs[7]  = '{32'h00000001, 32'h00800000, 1'b0, 0,   27'h4000000, 27'h0000008, 8'h01, 4'b0001};
        vecs[8]  = '{32'h4E800000, 32'h00000000, 1'b0, 156, 27'h4000000, 27'h0000000, 8'h9D, 4'b0000};
        vecs[9]  = '{32'h7F800000, 32'h7F000000, 1'b0, 1,   27'h4000000, 27'h2000000, 8'hFF, 4'b0000};
        vecs[10] = '{32'h4C800000, 32'h3F800000, 1'b0, 26,  27'h4000000, 27'h0000001, 8'h99, 4'b0000};
        vecs[11] = '{32'h4D000000, 32'h3F800000, 1'b0, 27,  27'h4000000, 27'h0000001, 8'h9A, 4'b0000};
        vecs[12] = '{32'h3F800000, 32'hBF800000, 1'b1, 0,   27'h4000000, 27'h4000000, 8'h7F, 4'b0010};
        vecs[13] = '{32'h3F800000, 32'h40400000, 1'b1, 1,   27'h6000000, 27'h2000000, 8'h80, 4'b1011};

        rst_n = 1'b0; a = '0; b = '0; op = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_handshake", {30'd0, out_valid, in_ready}, 32'd1);
        check("reset_data", {5'd0, ma_mant | mb_mant}, 32'd0);
        check("reset_misc", {20'd0, exp_big, ma_sign, mb_sign, op_out, swapped}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].op);
            wait_done(lat);
            check($sformatf("v%0d_latency", i), lat, exp_latency(vecs[i].diff));
            check_outputs(vecs[i], $sformatf("v%0d", i));
            release_result();
        end

        // Back-pressure: hold DONE, try to inject a new operand meanwhile
        send(vecs[4].a, vecs[4].b, vecs[4].op);
        wait_done(lat);
        check("bp_latency", lat, exp_latency(vecs[4].diff));
        @(negedge clk);
        a = 32'h12345678; b = 32'h7F7FFFFF; op = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_hs", c), {30'd0, out_valid, in_ready}, 32'd2);
            check_outputs(vecs[4], $sformatf("bp_hold%0d", c));
        end
        @(negedge clk); in_valid = 1'b0;
        release_result();

        // Reset in the middle of a long shift discards the transaction
        send(vecs[2].a, vecs[2].b, vecs[2].op);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check("midreset_hs", {30'd0, out_valid, in_ready}, 32'd1);
        check("midreset_data", {5'd0, ma_mant | mb_mant}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("midreset_no_valid", seen, 0);
        check("midreset_outputs_zero", {5'd0, ma_mant | mb_mant}, 32'd0);
        send(vecs[1].a, vecs[1].b, vecs[1].op);
        wait_done(lat);
        check("post_reset_latency", lat, exp_latency(vecs[1].diff));
        check_outputs(vecs[1], "post_reset");
        release_result();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
